// File: rtl/vga_pkg.sv
// Shared VGA timing definitions used by the timing generator and the sync receiver.
package vga_pkg;

  typedef enum logic [1:0] {
    HUNT,
    MEASURE,
    WAIT_V,
    LOCKED
  } state_t;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_START  = 64;
  localparam int unsigned V_START  = 16;

endpackage

// File: rtl/vga_sync_edge.sv
// Sync input conditioning: normalise polarity to active-high, two-flop stage, leading-edge pulse.
module vga_sync_edge #(
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sync,
  output logic lead
);

  logic meta;
  logic stable;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      stable <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= sync ^ ~SYNC_POL;
      stable <= meta;
      prev   <= stable;
    end
  end

  assign lead = stable & ~prev;

endmodule

// File: rtl/vga_sync_receiver.sv
// Sink side of the VGA timing link: locks to raw h/v sync and regenerates
// pixel coordinates, display-enable and line/frame markers.
module vga_sync_receiver #(
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned H_START  = vga_pkg::H_START,
  parameter int unsigned V_START  = vga_pkg::V_START,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned CW       = 10,
  parameter int unsigned MISS_MAX = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vga_h_sync,
  input  logic          vga_v_sync,
  output logic          locked,
  output logic          rx_de,
  output logic [CW-1:0] rx_x,
  output logic [CW-1:0] rx_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] line_len
);

  import vga_pkg::state_t;
  import vga_pkg::HUNT;
  import vga_pkg::MEASURE;
  import vga_pkg::WAIT_V;
  import vga_pkg::LOCKED;

  localparam int unsigned MW = (MISS_MAX > 1) ? $clog2(MISS_MAX) : 1;
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] HS        = CW'(H_START);
  localparam logic [CW-1:0] HE        = CW'(H_START + H_ACTIVE);
  localparam logic [CW-1:0] VS        = CW'(V_START);
  localparam logic [CW-1:0] VE        = CW'(V_START + V_ACTIVE);

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   h_cnt;
  logic [CW-1:0]   v_cnt;
  logic [MW-1:0]   miss_cnt;
  logic            h_edge;
  logic            v_edge;
  logic            timeout;
  logic            len_ok;
  logic            next_lock;
  logic            in_win;

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_h_edge (
    .clk   (clk),
    .reset (reset),
    .sync  (vga_h_sync),
    .lead  (h_edge)
  );

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_v_edge (
    .clk   (clk),
    .reset (reset),
    .sync  (vga_v_sync),
    .lead  (v_edge)
  );

  always_comb begin
    next_state = state;
    timeout    = (h_cnt == CNT_MAX);
    len_ok     = ((h_cnt + CW'(1)) == line_len);
    unique case (state)
      HUNT:    if (h_edge) next_state = MEASURE;
      MEASURE: if (h_edge) next_state = WAIT_V;
      // A bad line length takes priority over a coincident v-edge.
      WAIT_V: begin
        if (h_edge && !len_ok) next_state = HUNT;
        else if (v_edge)       next_state = LOCKED;
      end
      LOCKED:  if (h_edge && !len_ok && miss_cnt == MISS_LAST) next_state = HUNT;
      default: next_state = HUNT;
    endcase
    if (timeout) next_state = HUNT;
    next_lock = (next_state == LOCKED);
    in_win    = (h_cnt >= HS) && (h_cnt < HE) && (v_cnt >= VS) && (v_cnt < VE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      h_cnt       <= '0;
      v_cnt       <= '0;
      miss_cnt    <= '0;
      line_len    <= '0;
      locked      <= 1'b0;
      rx_de       <= 1'b0;
      rx_x        <= '0;
      rx_y        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state <= next_state;

      if (h_edge)        h_cnt <= '0;
      else if (!timeout) h_cnt <= h_cnt + CW'(1);

      if (v_edge)                          v_cnt <= '0;
      else if (h_edge && v_cnt != CNT_MAX) v_cnt <= v_cnt + CW'(1);

      if (state == MEASURE && h_edge) line_len <= h_cnt + CW'(1);

      if (!next_lock)                   miss_cnt <= '0;
      else if (state == LOCKED && h_edge) miss_cnt <= len_ok ? '0 : miss_cnt + MW'(1);

      // Outputs follow the post-transition state so leaving LOCKED clears them at once.
      locked      <= next_lock;
      rx_de       <= next_lock && in_win;
      rx_x        <= (next_lock && in_win) ? h_cnt - HS : '0;
      rx_y        <= (next_lock && in_win) ? v_cnt - VS : '0;
      line_start  <= h_edge;
      frame_start <= v_edge && next_lock;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a scaled-down raster (40 clk lines, 12-line frames).
module tb_vga_sync_receiver;

  localparam int HS_W        = 5;
  localparam int VS_LINES    = 2;
  localparam int FRAME_LINES = 12;
  localparam int LINE_CLKS   = 40;
  localparam int LONG_CLKS   = 44;

  logic       clk;
  logic       reset;
  logic       h_sync;
  logic       v_sync;
  logic       h_sync_inv;
  logic       v_sync_inv;

  logic       locked, rx_de, line_start, frame_start;
  logic [9:0] rx_x, rx_y, line_len;
  logic       locked_p, rx_de_p, line_start_p, frame_start_p;
  logic [9:0] rx_x_p, rx_y_p, line_len_p;
  logic [33:0] outs, outs_p;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int  gstep;
  int  hpos;
  int  vline;
  bit  gen_en;
  bit  hs_en;
  int  stretch_a;
  int  stretch_b;

  assign h_sync_inv = ~h_sync;
  assign v_sync_inv = ~v_sync;
  assign outs   = {locked, rx_de, rx_x, rx_y, line_start, frame_start, line_len};
  assign outs_p = {locked_p, rx_de_p, rx_x_p, rx_y_p, line_start_p, frame_start_p, line_len_p};

  vga_sync_receiver #(
    .SYNC_POL (1'b0),
    .H_START  (8),
    .V_START  (2),
    .H_ACTIVE (24),
    .V_ACTIVE (6),
    .CW       (10),
    .MISS_MAX (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vga_h_sync  (h_sync),
    .vga_v_sync  (v_sync),
    .locked      (locked),
    .rx_de       (rx_de),
    .rx_x        (rx_x),
    .rx_y        (rx_y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .line_len    (line_len)
  );

  vga_sync_receiver #(
    .SYNC_POL (1'b1),
    .H_START  (8),
    .V_START  (2),
    .H_ACTIVE (24),
    .V_ACTIVE (6),
    .CW       (10),
    .MISS_MAX (2)
  ) dut_pos (
    .clk         (clk),
    .reset       (reset),
    .vga_h_sync  (h_sync_inv),
    .vga_v_sync  (v_sync_inv),
    .locked      (locked_p),
    .rx_de       (rx_de_p),
    .rx_x        (rx_x_p),
    .rx_y        (rx_y_p),
    .line_start  (line_start_p),
    .frame_start (frame_start_p),
    .line_len    (line_len_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int line_clks(input int ln);
    return (ln == stretch_a || ln == stretch_b) ? LONG_CLKS : LINE_CLKS;
  endfunction

  // Drive one pixel of the raster, advance one clock, then sample point is #1 after the edge.
  task automatic step();
    if (gen_en) begin
      h_sync = !(hs_en && hpos < HS_W);
      v_sync = !(vline < VS_LINES);
    end else begin
      h_sync = 1'b1;
      v_sync = 1'b1;
    end
    @(posedge clk);
    #1;
    gstep++;
    if (gen_en) begin
      hpos++;
      if (hpos >= line_clks(vline)) begin
        hpos  = 0;
        vline = (vline + 1) % FRAME_LINES;
      end
    end
  endtask

  // Inverted-polarity instance must track the active-low instance cycle for cycle.
  always @(negedge clk) check("pol_match", 64'(outs_p), 64'(outs));

  initial begin
    int n, de_cnt, first_ofs, bad_idle, drop;
    logic [9:0] fx, fy, mx, my;

    reset = 1'b1; gen_en = 1'b0; hs_en = 1'b1;
    stretch_a = -1; stretch_b = -1;
    hpos = 0; vline = 0; gstep = 0;
    h_sync = 1'b1; v_sync = 1'b1;

    repeat (3) step();
    check("reset_outs", 64'(outs), 64'd0);

    // T1 / T6: clean raster from reset; frame 2 start has coincident h/v edges.
    reset = 1'b0; gen_en = 1'b1; gstep = 0;
    while (!locked && gstep < 2000) step();
    check("lock_time", 64'(gstep), 64'd483);
    check("lock_ls_fs", 64'({line_start, frame_start}), 64'd3);
    check("line_len", 64'(line_len), 64'd40);

    de_cnt = 0; first_ofs = -1; bad_idle = 0; fx = '0; fy = '0; mx = '0; my = '0;
    for (int i = 1; i <= 480; i++) begin
      step();
      if (rx_de) begin
        de_cnt++;
        if (first_ofs < 0) begin
          first_ofs = i; fx = rx_x; fy = rx_y;
        end
        if (rx_x > mx) mx = rx_x;
        if (rx_y > my) my = rx_y;
      end else if (rx_x != '0 || rx_y != '0) begin
        bad_idle++;
      end
    end
    check("de_per_frame", 64'(de_cnt), 64'd144);
    check("first_de_ofs", 64'(first_ofs), 64'd89);
    check("first_de_xy", 64'({fx, fy}), 64'd0);
    check("max_x", 64'(mx), 64'd23);
    check("max_y", 64'(my), 64'd5);
    check("idle_xy_zero", 64'(bad_idle), 64'd0);
    check("frame_period", 64'(frame_start), 64'd1);

    // T2: one long line is tolerated.
    stretch_a = 4; n = 0; drop = 0;
    do begin
      step(); n++;
      if (!locked) drop++;
    end while (!frame_start && n < 600);
    check("stretch1_period", 64'(n), 64'd484);
    check("stretch1_held", 64'(drop), 64'd0);
    stretch_a = -1;

    // T2: two consecutive long lines drop lock on the second measuring edge.
    stretch_a = 4; stretch_b = 5; n = 0;
    do begin
      step(); n++;
    end while (locked && n < 600);
    check("loss_ofs", 64'(n), 64'd248);
    check("loss_line_start", 64'(line_start), 64'd1);
    check("loss_de", 64'(rx_de), 64'd0);
    stretch_a = -1; stretch_b = -1;
    n = 0; de_cnt = 0;
    do begin
      step(); n++;
      if (rx_de) de_cnt++;
    end while (!locked && n < 1500);
    check("relock_ofs", 64'(n), 64'd240);
    check("unlocked_de", 64'(de_cnt), 64'd0);

    // T3: hsync held inactive, counter saturates and forces HUNT.
    hs_en = 1'b0; n = 0;
    do begin
      step(); n++;
    end while (locked && n < 2000);
    check("timeout_ofs", 64'(n), 64'd1024);
    check("timeout_de", 64'(rx_de), 64'd0);
    repeat (20) step();
    check("timeout_hold", 64'({locked, rx_de}), 64'd0);
    hs_en = 1'b1; n = 0;
    do begin
      step(); n++;
    end while (!(locked && frame_start) && n < 3000);
    check("relock_after_timeout", 64'({locked, frame_start}), 64'd3);

    // T4: one-cycle reset in the middle of the first active line.
    n = 0;
    do begin
      step(); n++;
    end while (!rx_de && n < 200);
    check("t4_first_de_ofs", 64'(n), 64'd89);
    reset = 1'b1;
    step();
    check("t4_reset_outs", 64'(outs), 64'd0);
    reset = 1'b0; n = 0;
    do begin
      step(); n++;
    end while (!locked && n < 1500);
    check("t4_relock_ofs", 64'(n), 64'd390);
    check("t4_line_len", 64'(line_len), 64'd40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
